// File: rtl/serial_add_sub.sv
// Bit-serial two's complement adder/subtractor: one bit per cycle, LSB first, registered carry.
// Optional build macro SERIAL_ADD_SUB_SAT_EN saturates the result on signed overflow.
`timescale 1ns/1ps

module serial_add_sub_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             cy_q;

  logic             accept_c;
  logic             last_c;
  logic             p_c, g1_c, g2_c;
  logic             fa_s_c, fa_co_c;
  logic             ovf_c;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] fin_c;

  // Full-adder stage: two half-adder cells plus carry OR
  serial_add_sub_ha u_ha0 (.x(a_q[0]), .y(b_q[0]), .s(p_c),    .c(g1_c));
  serial_add_sub_ha u_ha1 (.x(p_c),    .y(cy_q),   .s(fa_s_c), .c(g2_c));
  assign fa_co_c = g1_c | g2_c;

  assign last_c = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
  assign ovf_c  = cy_q ^ fa_co_c;
  assign res_c  = {fa_s_c, acc_q};

  // On the final bit a_q[0] holds the latched sign of a
  always_comb begin
    fin_c = res_c;
`ifdef SERIAL_ADD_SUB_SAT_EN
    if (ovf_c) begin
      fin_c = a_q[0] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          accept_c = 1'b1;
        end
      end
      RUN: begin
        if (last_c) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d  = RUN;
          accept_c = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

  // Operand shift registers; subtract is a + ~b + 1 via the initial carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      cy_q     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept_c) begin
      a_q   <= a;
      b_q   <= mode ? ~b : b;
      cy_q  <= mode;
      cnt_q <= '0;
      acc_q <= '0;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      cy_q  <= fa_co_c;
      acc_q <= res_c[WIDTH-1:1];
      cnt_q <= cnt_q + CW'(1);
      if (last_c) begin
        sum      <= fin_c;
        carry    <= fa_co_c;
        overflow <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8): directed table, corner sequences, random vs. arithmetic model.
`timescale 1ns/1ps

module tb_serial_add_sub;

  localparam int W = 8;

`ifdef SERIAL_ADD_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [W-1:0] a, b;
  logic [W-1:0] sum;
  logic         carry, overflow, busy, done;

  int errors = 0;
  int checks = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .sum(sum), .carry(carry), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic
  function automatic void model(input logic [7:0] ta, input logic [7:0] tb_, input logic tm,
                                output logic [7:0] s, output logic c, output logic o);
    int sr, ur;
    sr = tm ? int'($signed(ta)) - int'($signed(tb_)) : int'($signed(ta)) + int'($signed(tb_));
    ur = tm ? int'(ta) - int'(tb_) : int'(ta) + int'(tb_);
    o  = (sr > 127) || (sr < -128);
    c  = tm ? (ta >= tb_) : (ur > 255);
    s  = 8'(ur);
    if (SAT && o) s = ta[7] ? 8'h80 : 8'h7F;
  endfunction

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tm,
                        input logic [7:0] es, input logic ec, input logic eo, input string nm);
    logic [7:0] ps;
    logic       pc, po;
    int         cyc;
    bit         busy_ok, hold_ok;
    @(negedge clk);
    ps = sum; pc = carry; po = overflow;
    a = ta; b = tb_; mode = tm; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
    cyc = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!done && cyc < 20) begin
      if (!busy) busy_ok = 1'b0;
      if (sum !== ps || carry !== pc || overflow !== po) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"}, 64'(cyc), 64'(W));
    chk({nm, " busy_in_run"}, 64'(busy_ok), 64'(1));
    chk({nm, " hold_prev"}, 64'(hold_ok), 64'(1));
    chk({nm, " sum"}, 64'(sum), 64'(es));
    chk({nm, " carry"}, 64'(carry), 64'(ec));
    chk({nm, " overflow"}, 64'(overflow), 64'(eo));
    chk({nm, " busy_at_done"}, 64'(busy), 64'(0));
    @(negedge clk);
    chk({nm, " done_width"}, 64'(done), 64'(0));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  vec_t       vecs[7];
  logic [7:0] ms;
  logic       mc, mo;
  logic [7:0] ra, rb;
  logic       rm;
  int         cyc, ndone;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h01, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    #12;
    chk("reset sum", 64'(sum), 64'(0));
    chk("reset flags", 64'({carry, overflow, busy, done}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].s, vecs[i].c, vecs[i].o,
             $sformatf("vec%0d", i));
    end

    // Start held high through RUN with changing operands
    @(negedge clk);
    a = 8'h10; b = 8'h20; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!done && cyc < 20) begin
      a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
      start = (cyc < W - 1);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("hold_start latency", 64'(cyc), 64'(W));
    chk("hold_start sum", 64'(sum), 64'(8'h30));
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("hold_start single_done", 64'(ndone), 64'(0));
    chk("hold_start idle", 64'(busy), 64'(0));

    // Reset in the middle of RUN
    @(negedge clk);
    a = 8'h21; b = 8'h13; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort sum", 64'(sum), 64'(0));
    chk("abort flags", 64'({carry, overflow, busy, done}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("abort no_done", 64'(ndone), 64'(0));
    model(8'h21, 8'h13, 1'b0, ms, mc, mo);
    run_op(8'h21, 8'h13, 1'b0, ms, mc, mo, "after_abort");

    // Back-to-back: new start accepted in the DONE cycle
    @(negedge clk);
    a = 8'h05; b = 8'h03; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("b2b first latency", 64'(cyc), 64'(W));
    chk("b2b first sum", 64'(sum), 64'(8'h08));
    a = 8'h20; b = 8'h01; mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy_again", 64'({busy, done}), 64'(2'b10));
    wait_done(cyc);
    chk("b2b second latency", 64'(cyc), 64'(W));
    chk("b2b second sum", 64'(sum), 64'(8'h1F));
    chk("b2b second flags", 64'({carry, overflow}), 64'(2'b10));

    // Random operations against the arithmetic model
    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rm = 1'($urandom);
      if (k % 8 == 0) begin ra = 8'h7F; end
      if (k % 8 == 1) begin ra = 8'h80; end
      model(ra, rb, rm, ms, mc, mo);
      run_op(ra, rb, rm, ms, mc, mo, $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal values are 2 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one operation.
REQ-005 The block SHALL have port mode, input, 1 bit: 0 = add (a+b), 1 = subtract (a-b).
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: the operands, two's complement.
REQ-007 The block SHALL have port sum, output, WIDTH bits: the registered result.
REQ-008 The block SHALL have port carry, output, 1 bit: carry-out for add; not-borrow for subtract (1 = no borrow).
REQ-009 The block SHALL have port overflow, output, 1 bit: signed overflow of the last result.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when a new result is presented.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL be accepted at the rising edge and SHALL latch a, b and mode internally. Transition: RUN.
REQ-014 On acceptance, the internal carry SHALL be initialised to mode, and the b operand SHALL be inverted when mode=1.
REQ-015 Start SHALL be ignored while in RUN; latched operands SHALL NOT change mid-operation.
REQ-016 In RUN, one bit per cycle SHALL be processed, LSB first, through a full-adder stage (two half-adder cells plus carry OR) with a registered carry.
REQ-017 After exactly WIDTH RUN cycles, the FSM SHALL transition RUN -> DONE.
REQ-018 At the edge entering DONE, sum, carry and overflow SHALL update together.
REQ-019 Latency: done SHALL be high for exactly one cycle, beginning WIDTH rising edges after the accepting edge.
REQ-020 DONE SHALL return to IDLE on the next edge, or go to RUN if start=1 at that edge (back-to-back operation).
REQ-021 busy SHALL be 1 exactly while the FSM is in RUN.
REQ-022 sum, carry and overflow SHALL hold the previous result throughout RUN and until the next DONE entry.
REQ-023 overflow SHALL equal the XOR of the carry into and the carry out of the MSB stage.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; the result SHALL NOT be widened.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, sum=0, carry=0, overflow=0, busy=0 and done=0, and clear all internal operand, bit-count and carry registers.
REQ-026 Reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-027 After rst_n deasserts, the first rising edge SHALL accept start normally.

Configuration
REQ-028 The saturation feature SHALL be controlled by macro SERIAL_ADD_SUB_SAT_EN.
- Defined: when overflow=1, sum SHALL be 0111..1 if latched a is non-negative, else 1000..0; overflow still reads 1.
- Undefined: sum SHALL always be the wrapped result.
- carry, done and latency SHALL be identical in both builds.

Verification (WIDTH=8)
REQ-029 Add, a=05, b=03, start pulse -> sum=08, carry=0, overflow=0; busy high 8 cycles; done 8 edges after accept.
REQ-030 Add, a=FF, b=01 -> sum=00, carry=1, overflow=0. Subtract, a=03, b=05 -> sum=FE, carry=0, overflow=0.
REQ-031 Add, a=7F, b=01 -> without macro: sum=80, overflow=1. With SERIAL_ADD_SUB_SAT_EN: sum=7F, overflow=1. Subtract, a=80, b=01 with macro -> sum=80, overflow=1.
REQ-032 Start held high during RUN with changed a/b -> result matches the originally latched operands; a single done pulse.
REQ-033 rst_n pulsed low at RUN cycle 4 -> all outputs 0 immediately; no done pulse; a following start gives a correct result.
REQ-034 Start high in the DONE cycle with new operands -> busy reasserts next cycle; second done follows exactly 8 edges later.
